// File: rtl/csr_timer_compare_pkg.sv
// Shared CSR layout for the compare timer: control bit positions, prescale field, control struct.
package csr_timer_compare_pkg;

    localparam int CTRL_ENABLE           = 0;
    localparam int CTRL_PERIODIC         = 1;
    localparam int CTRL_IRQ_ENABLE       = 2;
    localparam int CTRL_MATCH_PENDING    = 3;
    localparam int CTRL_OVERFLOW_PENDING = 4;
    localparam int CTRL_PRESCALE_LSB     = 8;
    localparam int CTRL_PRESCALE_MSB     = 15;
    localparam int PRESCALE_WIDTH        = CTRL_PRESCALE_MSB - CTRL_PRESCALE_LSB + 1;

    typedef struct packed {
        logic [PRESCALE_WIDTH-1:0] prescale;
        logic                      overflow_pending;
        logic                      match_pending;
        logic                      irq_enable;
        logic                      periodic;
        logic                      enable;
    } ctrl_t;

    function automatic logic [31:0] pack_ctrl(input ctrl_t c);
        logic [31:0] r;
        r = '0;
        r[CTRL_ENABLE]           = c.enable;
        r[CTRL_PERIODIC]         = c.periodic;
        r[CTRL_IRQ_ENABLE]       = c.irq_enable;
        r[CTRL_MATCH_PENDING]    = c.match_pending;
        r[CTRL_OVERFLOW_PENDING] = c.overflow_pending;
        r[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB] = c.prescale;
        return r;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides qualified ticks: step fires on every (prescale+1)-th advance.
module timer_prescaler
    import csr_timer_compare_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      advance,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      step
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    logic [PRESCALE_WIDTH-1:0] prescale_count;

    assign step = advance && (prescale_count == prescale);

    // clear restarts the interval but does not suppress a step already due this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_count <= '0;
        end else if (clear) begin
            prescale_count <= '0;
        end else if (advance) begin
            prescale_count <= step ? '0 : prescale_count + ONE;
        end
    end

endmodule

// File: rtl/csr_timer_compare.sv
// CSR-mapped WIDTH-bit timer with compare match, overflow detection and a W1C-pending interrupt.
module csr_timer_compare
    import csr_timer_compare_pkg::*;
#(
    parameter int         WIDTH                 = 64,  // legal 33..64
    parameter logic [11:0] ADDRESS_COUNT_LOWER   = 12'h000,
    parameter logic [11:0] ADDRESS_COUNT_UPPER   = 12'h000,
    parameter logic [11:0] ADDRESS_COMPARE_LOWER = 12'h000,
    parameter logic [11:0] ADDRESS_COMPARE_UPPER = 12'h000,
    parameter logic [11:0] ADDRESS_CONTROL       = 12'h000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csrWriteEnable,
    input  logic [11:0]      csrWriteAddress,
    input  logic [31:0]      csrWriteData,
    input  logic             csrReadEnable,
    input  logic [11:0]      csrReadAddress,
    output logic [31:0]      csrReadData,
    output logic             csrRequestOutput,
    input  logic             count,
    output logic [WIDTH-1:0] value,
    output logic             timerInterrupt
);

    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] compare;
    ctrl_t            ctrl;
    logic             step;

    wire wr_cnt_lo = csrWriteEnable && (csrWriteAddress == ADDRESS_COUNT_LOWER);
    wire wr_cnt_hi = csrWriteEnable && (csrWriteAddress == ADDRESS_COUNT_UPPER);
    wire wr_cmp_lo = csrWriteEnable && (csrWriteAddress == ADDRESS_COMPARE_LOWER);
    wire wr_cmp_hi = csrWriteEnable && (csrWriteAddress == ADDRESS_COMPARE_UPPER);
    wire wr_ctrl   = csrWriteEnable && (csrWriteAddress == ADDRESS_CONTROL);
    wire cnt_write = wr_cnt_lo || wr_cnt_hi;

    timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .advance  (ctrl.enable && count),
        .clear    (wr_ctrl),
        .prescale (ctrl.prescale),
        .step     (step)
    );

    // a software write to the counter swallows the step and any event it would raise
    wire step_eff = step && !cnt_write;
    wire is_equal = (counter == compare);
    wire match    = step_eff && is_equal;
    wire overflow = step_eff && !is_equal && (&counter);

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            compare <= '1;
            ctrl    <= '{prescale: '0, overflow_pending: 1'b0, match_pending: 1'b0,
                         irq_enable: 1'b0, periodic: 1'b0, enable: 1'b1};
        end else begin
            if (cnt_write) begin
                if (wr_cnt_lo) counter[31:0]       <= csrWriteData;
                if (wr_cnt_hi) counter[WIDTH-1:32] <= csrWriteData[WIDTH-33:0];
            end else if (step) begin
                counter <= (match && ctrl.periodic) ? '0 : counter + COUNT_ONE;
            end
            if (wr_cmp_lo) compare[31:0]       <= csrWriteData;
            if (wr_cmp_hi) compare[WIDTH-1:32] <= csrWriteData[WIDTH-33:0];
            if (wr_ctrl) begin
                ctrl.enable     <= csrWriteData[CTRL_ENABLE];
                ctrl.periodic   <= csrWriteData[CTRL_PERIODIC];
                ctrl.irq_enable <= csrWriteData[CTRL_IRQ_ENABLE];
                ctrl.prescale   <= csrWriteData[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
            end
            // set events beat a same-cycle write-one-to-clear
            ctrl.match_pending <= match ||
                (ctrl.match_pending && !(wr_ctrl && csrWriteData[CTRL_MATCH_PENDING]));
            ctrl.overflow_pending <= overflow ||
                (ctrl.overflow_pending && !(wr_ctrl && csrWriteData[CTRL_OVERFLOW_PENDING]));
        end
    end

    logic [31:0] count_upper;
    logic [31:0] compare_upper;

    always_comb begin
        count_upper                 = '0;
        compare_upper               = '0;
        count_upper[WIDTH-33:0]     = counter[WIDTH-1:32];
        compare_upper[WIDTH-33:0]   = compare[WIDTH-1:32];
    end

    always_comb begin
        csrReadData      = '0;
        csrRequestOutput = 1'b0;
        if (csrReadEnable) begin
            csrRequestOutput = 1'b1;
            if (csrReadAddress == ADDRESS_COUNT_LOWER)        csrReadData = counter[31:0];
            else if (csrReadAddress == ADDRESS_COUNT_UPPER)   csrReadData = count_upper;
            else if (csrReadAddress == ADDRESS_COMPARE_LOWER) csrReadData = compare[31:0];
            else if (csrReadAddress == ADDRESS_COMPARE_UPPER) csrReadData = compare_upper;
            else if (csrReadAddress == ADDRESS_CONTROL)       csrReadData = pack_ctrl(ctrl);
            else                                              csrRequestOutput = 1'b0;
        end
    end

    assign value          = counter;
    assign timerInterrupt = ctrl.irq_enable && (ctrl.match_pending || ctrl.overflow_pending);

endmodule

// File: tb/tb_csr_timer_compare.sv
// Directed bench: reads push expected CSR/value/irq into a scoreboard, a negedge monitor checks them.
module tb_csr_timer_compare;

    localparam int W = 40;
    localparam logic [11:0] A_CNTL = 12'h100;
    localparam logic [11:0] A_CNTH = 12'h101;
    localparam logic [11:0] A_CMPL = 12'h102;
    localparam logic [11:0] A_CMPH = 12'h103;
    localparam logic [11:0] A_CTRL = 12'h104;
    localparam logic [W-1:0] ONES  = 40'hFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [11:0]  waddr;
    logic [31:0]  wdata;
    logic         re;
    logic [11:0]  raddr;
    logic [31:0]  rdata;
    logic         rreq;
    logic         count;
    logic [W-1:0] value;
    logic         irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic         req;
        logic [31:0]  data;
        logic [W-1:0] val;
        logic         irq;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    csr_timer_compare #(
        .WIDTH                 (W),
        .ADDRESS_COUNT_LOWER   (A_CNTL),
        .ADDRESS_COUNT_UPPER   (A_CNTH),
        .ADDRESS_COMPARE_LOWER (A_CMPL),
        .ADDRESS_COMPARE_UPPER (A_CMPH),
        .ADDRESS_CONTROL       (A_CTRL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .csrWriteEnable   (we),
        .csrWriteAddress  (waddr),
        .csrWriteData     (wdata),
        .csrReadEnable    (re),
        .csrReadAddress   (raddr),
        .csrReadData      (rdata),
        .csrRequestOutput (rreq),
        .count            (count),
        .value            (value),
        .timerInterrupt   (irq)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_field(input string name, input string field,
                               input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%0h expected=%0h", name, field, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (re) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read got=%0h expected=none", rdata);
            end else begin
                mon_e = sb.pop_front();
                check_field(mon_e.name, "req",   {63'b0, rreq},  {63'b0, mon_e.req});
                check_field(mon_e.name, "data",  {32'b0, rdata}, {32'b0, mon_e.data});
                check_field(mon_e.name, "value", {24'b0, value}, {24'b0, mon_e.val});
                check_field(mon_e.name, "irq",   {63'b0, irq},   {63'b0, mon_e.irq});
            end
        end
    end

    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        cycle();
        we = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [11:0] a, input logic req,
                           input logic [31:0] d, input logic [W-1:0] v, input logic i);
        exp_t e;
        e.name = name; e.req = req; e.data = d; e.val = v; e.irq = i;
        sb.push_back(e);
        re = 1'b1; raddr = a;
        cycle();
        re = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; re = 1'b0; raddr = '0; count = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        do_read("rst_ctrl",   A_CTRL, 1'b1, 32'h1,         '0, 1'b0);
        do_read("rst_cmp_lo", A_CMPL, 1'b1, 32'hFFFF_FFFF, '0, 1'b0);
        do_read("rst_cmp_hi", A_CMPH, 1'b1, 32'hFF,        '0, 1'b0);

        // prescale 0: one step per qualified count
        count = 1'b1;
        for (int i = 0; i < 4; i++) do_read("inc_p0", A_CNTL, 1'b1, 32'(i), W'(i), 1'b0);
        count = 1'b0;

        // prescale 3: one step every 4 cycles, control write restarts the interval
        do_write(A_CTRL, 32'h0301);
        count = 1'b1;
        for (int i = 0; i < 5; i++)
            do_read("presc3", A_CNTL, 1'b1, (i == 4) ? 32'd5 : 32'd4, (i == 4) ? W'(5) : W'(4), 1'b0);
        do_write(A_CTRL, 32'h0301);
        for (int i = 0; i < 5; i++)
            do_read("presc3_restart", A_CNTL, 1'b1, (i == 4) ? 32'd6 : 32'd5,
                    (i == 4) ? W'(6) : W'(5), 1'b0);
        count = 1'b0;

        // periodic compare at 5 with interrupt
        do_write(A_CNTL, 32'h0); do_write(A_CNTH, 32'h0);
        do_write(A_CMPL, 32'h5); do_write(A_CMPH, 32'h0);
        do_write(A_CTRL, 32'h7);
        count = 1'b1;
        for (int i = 0; i < 7; i++)
            do_read("periodic", A_CTRL, 1'b1, (i == 6) ? 32'hF : 32'h7,
                    (i == 6) ? W'(0) : W'(i), (i == 6));
        count = 1'b0;
        do_write(A_CTRL, 32'hF);
        do_read("w1c_match", A_CTRL, 1'b1, 32'h7, W'(1), 1'b0);

        // overflow from all-ones
        do_write(A_CTRL, 32'h5);
        do_write(A_CNTL, 32'hFFFF_FFFF); do_write(A_CNTH, 32'hFF);
        count = 1'b1;
        do_read("ovf_pre", A_CTRL, 1'b1, 32'h5, ONES, 1'b0);
        count = 1'b0;
        do_read("ovf_post", A_CTRL, 1'b1, 32'h15, '0, 1'b1);
        do_write(A_CTRL, 32'h15);
        do_read("w1c_ovf", A_CTRL, 1'b1, 32'h5, '0, 1'b0);

        // all-ones that matches compare: match only, no overflow
        do_write(A_CMPL, 32'hFFFF_FFFF); do_write(A_CMPH, 32'hFF);
        do_write(A_CNTL, 32'hFFFF_FFFF); do_write(A_CNTH, 32'hFF);
        count = 1'b1;
        do_read("match_ones_pre", A_CTRL, 1'b1, 32'h5, ONES, 1'b0);
        count = 1'b0;
        do_read("match_ones_post", A_CTRL, 1'b1, 32'hD, '0, 1'b1);
        do_write(A_CTRL, 32'hD);

        // counter write beats a would-be matching step
        do_write(A_CMPL, 32'h0); do_write(A_CMPH, 32'h0);
        count = 1'b1;
        do_write(A_CNTL, 32'h1234);
        count = 1'b0;
        do_read("wr_beats_step", A_CNTL, 1'b1, 32'h1234, W'(32'h1234), 1'b0);
        do_read("wr_no_match",   A_CTRL, 1'b1, 32'h5,    W'(32'h1234), 1'b0);

        // match beats same-cycle W1C
        do_write(A_CMPL, 32'h1234);
        count = 1'b1;
        do_write(A_CTRL, 32'hD);
        count = 1'b0;
        do_read("w1c_vs_match", A_CTRL, 1'b1, 32'hD, W'(32'h1235), 1'b1);
        do_write(A_CTRL, 32'hD);
        do_read("w1c_clear", A_CTRL, 1'b1, 32'h5, W'(32'h1235), 1'b0);

        // upper half zero-extension and unmapped read
        do_write(A_CNTH, 32'hFFFF_FFFF);
        do_read("upper_zext", A_CNTH, 1'b1, 32'hFF, 40'hFF_0000_1235, 1'b0);
        do_read("unmapped",   12'h3FF, 1'b0, 32'h0, 40'hFF_0000_1235, 1'b0);
        do_read("cmp_hi",     A_CMPH, 1'b1, 32'h0, 40'hFF_0000_1235, 1'b0);

        // reset overrides concurrent write and step
        rst = 1'b1; count = 1'b1; we = 1'b1; waddr = A_CNTL; wdata = 32'h55;
        cycle();
        rst = 1'b0; count = 1'b0; we = 1'b0;
        do_read("rst_override", A_CTRL, 1'b1, 32'h1,         '0, 1'b0);
        do_read("rst_cmp",      A_CMPL, 1'b1, 32'hFFFF_FFFF, '0, 1'b0);

        cycle(); cycle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
